ysyx_22040210_ras_commit: RTL and testbench

Architectural (commit-side) return address stack: the counterpart of the fetch-side speculative RAS.
- Updated only by committed call/return instructions from the writeback/commit stage.
- On a pipeline redirect (mispredict flush), streams its entire contents plus head pointer back to the fetch-side RAS over a valid/ready write port, repairing speculative corruption.
- Sits beside the commit stage and drives the fetch-side RAS repair inputs.

---
 rtl/ysyx_22040210_ras_commit_if.sv | 47 ++++
 rtl/ysyx_22040210_ras_commit.sv | 162 ++++++++++++++++
 tb/tb_ysyx_22040210_ras_commit.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040210_ras_commit_if.sv
// Commit-side RAS bus: committed call/return stream in, repair write port out.
// The master modport is the commit RAS; the slave modport is its environment
// (commit stage plus fetch-side RAS).
interface ysyx_22040210_ras_commit_if #(
   parameter int unsigned AW   = 4,
   parameter int unsigned XLEN = 64
);
   logic            commit_valid_i;
   logic [2:0]      commit_jumpop_i;
   logic [XLEN-1:0] commit_retaddr_i;
   logic            restore_req_i;
   logic            restore_wr_valid_o;
   logic            restore_wr_ready_i;
   logic [AW-1:0]   restore_wr_idx_o;
   logic [XLEN-1:0] restore_wr_data_o;
   logic [AW-1:0]   restore_ptr_o;
   logic            restore_done_o;
   logic            commit_stall_o;

   modport master (
      input  commit_valid_i,
      input  commit_jumpop_i,
      input  commit_retaddr_i,
      input  restore_req_i,
      input  restore_wr_ready_i,
      output restore_wr_valid_o,
      output restore_wr_idx_o,
      output restore_wr_data_o,
      output restore_ptr_o,
      output restore_done_o,
      output commit_stall_o
   );

   modport slave (
      output commit_valid_i,
      output commit_jumpop_i,
      output commit_retaddr_i,
      output restore_req_i,
      output restore_wr_ready_i,
      input  restore_wr_valid_o,
      input  restore_wr_idx_o,
      input  restore_wr_data_o,
      input  restore_ptr_o,
      input  restore_done_o,
      input  commit_stall_o
   );
endinterface

// File: rtl/ysyx_22040210_ras_commit.sv
// Architectural return address stack, updated by committed calls/returns only.
// On a redirect it streams every entry, then the head pointer, to the
// fetch-side RAS so speculative corruption there is repaired.
// Optional macro YSYX_22040210_RAS_COMMIT_PERF_EN adds saturating
// overflow/underflow event counters.
module ysyx_22040210_ras_commit #(
   parameter int unsigned DEPTH           = 16,
   parameter int unsigned AW              = 4,
   parameter int unsigned XLEN            = 64,
   parameter logic [2:0]  BtbCallOp       = 3'd1,
   parameter logic [2:0]  BtbRetOp        = 3'd2,
   parameter logic [2:0]  BtbCallAndRetOp = 3'd3
) (
   input logic                           clk,
   input logic                           rst,
   ysyx_22040210_ras_commit_if.master    bus
`ifdef YSYX_22040210_RAS_COMMIT_PERF_EN
   ,
   output logic [31:0]                   perf_overflow_o,
   output logic [31:0]                   perf_underflow_o
`endif
);

   typedef enum logic [1:0] {StIdle, StCopy, StDone} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [AW-1:0]   head_q, head_d;
   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] mem_d [DEPTH];
   logic            busy;
   logic            accept;
   logic            push;
   logic            pop;

   // Commits are frozen for the whole repair so the streamed image is consistent.
   assign busy   = (state_q != StIdle);
   assign accept = bus.commit_valid_i & ~busy;
   assign push   = accept & ((bus.commit_jumpop_i == BtbCallOp) |
                             (bus.commit_jumpop_i == BtbCallAndRetOp));
   assign pop    = accept & (bus.commit_jumpop_i == BtbRetOp);

   // Stack update: push writes at head then bumps it; pop only moves head back.
   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      if (push) begin
         mem_d[head_q] = bus.commit_retaddr_i;
         head_d        = head_q + 1'b1;
      end else if (pop) begin
         head_d = head_q - 1'b1;
      end
   end

   // Stack storage and head pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q <= '0;
      end else begin
         mem_q  <= mem_d;
         head_q <= head_d;
      end
   end

   // Repair FSM: next state and all repair-port outputs.
   always_comb begin
      state_d                = state_q;
      idx_d                  = idx_q;
      bus.restore_wr_valid_o = 1'b0;
      bus.restore_wr_idx_o   = '0;
      bus.restore_wr_data_o  = '0;
      bus.restore_ptr_o      = '0;
      bus.restore_done_o     = 1'b0;
      bus.commit_stall_o     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.restore_req_i) begin
               state_d = StCopy;
               idx_d   = '0;
            end
         end
         StCopy: begin
            bus.commit_stall_o     = 1'b1;
            bus.restore_wr_valid_o = 1'b1;
            bus.restore_wr_idx_o   = idx_q;
            bus.restore_wr_data_o  = mem_q[idx_q];
            // A fresh request restarts the copy even if this beat is accepted.
            if (bus.restore_req_i) begin
               idx_d = '0;
            end else if (bus.restore_wr_ready_i) begin
               if (idx_q == AW'(DEPTH - 1)) begin
                  state_d = StDone;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StDone: begin
            bus.commit_stall_o = 1'b1;
            bus.restore_done_o = 1'b1;
            bus.restore_ptr_o  = head_q;
            if (bus.restore_req_i) begin
               state_d = StCopy;
               idx_d   = '0;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end

   // FSM state and copy index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

`ifdef YSYX_22040210_RAS_COMMIT_PERF_EN
   logic [31:0] ovf_q, ovf_d;
   logic [31:0] unf_q, unf_d;

   // Saturating wrap-event counters; a restore leaves them untouched.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (push && (head_q == AW'(DEPTH - 1)) && (ovf_q != '1)) begin
         ovf_d = ovf_q + 32'd1;
      end
      if (pop && (head_q == '0) && (unf_q != '1)) begin
         unf_d = unf_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign perf_overflow_o  = ovf_q;
   assign perf_underflow_o = unf_q;
`endif

endmodule

// File: tb/tb_ysyx_22040210_ras_commit.sv
// Self-checking bench for the commit-side RAS: a plain array/pointer model of
// the stack, a per-cycle compare process on the repair port, and directed
// scenarios with hand-computed literal expectations.
module tb_ysyx_22040210_ras_commit;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int XLEN  = 64;
   localparam logic [2:0] OpNone    = 3'd0;
   localparam logic [2:0] OpCall    = 3'd1;
   localparam logic [2:0] OpRet     = 3'd2;
   localparam logic [2:0] OpCallRet = 3'd3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ysyx_22040210_ras_commit_if #(.AW(AW), .XLEN(XLEN)) bus ();

`ifdef YSYX_22040210_RAS_COMMIT_PERF_EN
   logic [31:0] perf_ovf;
   logic [31:0] perf_unf;
`endif

   ysyx_22040210_ras_commit #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .XLEN  (XLEN)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus.master)
`ifdef YSYX_22040210_RAS_COMMIT_PERF_EN
      ,
      .perf_overflow_o  (perf_ovf),
      .perf_underflow_o (perf_unf)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: stack contents and head as plain integers.
   logic [63:0] model_mem [DEPTH];
   int          model_head;
   bit          model_busy;

   // Observation state kept by the compare process.
   int          exp_next;
   int          beats_acc;
   int          done_cnt;
   logic [63:0] beat_data [DEPTH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_head = 0;
      model_busy = 1'b0;
   endtask

   task automatic model_commit(input logic [2:0] op, input logic [63:0] addr);
      if (!model_busy) begin
         if (op == OpCall || op == OpCallRet) begin
            model_mem[model_head] = addr;
            model_head = (model_head + 1) % DEPTH;
         end else if (op == OpRet) begin
            model_head = (model_head + DEPTH - 1) % DEPTH;
         end
      end
   endtask

   // Compare process: repair-port outputs against the model every cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (!bus.restore_wr_valid_o) begin
            check("idle_idx", 64'(bus.restore_wr_idx_o), 64'd0);
            check("idle_data", bus.restore_wr_data_o, 64'd0);
         end else begin
            check("beat_idx", 64'(bus.restore_wr_idx_o), 64'(exp_next));
            check("beat_data", bus.restore_wr_data_o, model_mem[bus.restore_wr_idx_o]);
            beat_data[bus.restore_wr_idx_o] = bus.restore_wr_data_o;
            if (bus.restore_wr_ready_i && !bus.restore_req_i) begin
               exp_next++;
               beats_acc++;
            end
         end
         check("stall", 64'(bus.commit_stall_o),
               64'(bus.restore_wr_valid_o | bus.restore_done_o));
         if (bus.restore_done_o) begin
            check("done_ptr", 64'(bus.restore_ptr_o), 64'(model_head));
            check("done_beats", 64'(exp_next), 64'(DEPTH));
            done_cnt++;
         end else begin
            check("ptr_not_done", 64'(bus.restore_ptr_o), 64'd0);
         end
         if (bus.restore_req_i) begin
            exp_next  = 0;
            beats_acc = 0;
         end
      end
   end

   task automatic commit(input logic [2:0] op, input logic [63:0] addr);
      @(posedge clk);
      #1;
      bus.commit_valid_i   = 1'b1;
      bus.commit_jumpop_i  = op;
      bus.commit_retaddr_i = addr;
      @(posedge clk);
      model_commit(op, addr);
      #1;
      bus.commit_valid_i   = 1'b0;
      bus.commit_jumpop_i  = OpNone;
      bus.commit_retaddr_i = '0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_clear();
      exp_next  = 0;
      beats_acc = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // mode 0: ready high; mode 1: ready 1,0,0 repeating. restart re-requests at
   // index 7 and also presents a (to be ignored) return during the copy.
   task automatic restore(input int mode, input bit with_call, input logic [63:0] call_addr,
                          input bit restart, output int lat, output logic [AW-1:0] ptr);
      int cnt;
      bit got;
      @(posedge clk);
      #1;
      bus.restore_req_i = 1'b1;
      if (with_call) begin
         bus.commit_valid_i   = 1'b1;
         bus.commit_jumpop_i  = OpCall;
         bus.commit_retaddr_i = call_addr;
      end
      cnt = 0;
      got = 1'b0;
      lat = -1;
      ptr = '0;
      while (!got && cnt < 200) begin
         @(posedge clk);
         cnt++;
         if (cnt == 1) begin
            if (with_call) model_commit(OpCall, call_addr);
            model_busy = 1'b1;
         end
         #1;
         if (cnt == 1) begin
            bus.restore_req_i    = 1'b0;
            bus.commit_valid_i   = 1'b0;
            bus.commit_jumpop_i  = OpNone;
            bus.commit_retaddr_i = '0;
         end
         if (restart && cnt == 3) begin
            bus.commit_valid_i  = 1'b1;
            bus.commit_jumpop_i = OpRet;
         end
         if (restart && cnt == 4) begin
            bus.commit_valid_i  = 1'b0;
            bus.commit_jumpop_i = OpNone;
         end
         if (restart && cnt == 8) bus.restore_req_i = 1'b1;
         if (restart && cnt == 9) bus.restore_req_i = 1'b0;
         if (mode == 1) bus.restore_wr_ready_i = ((cnt - 1) % 3 == 0);
         @(negedge clk);
         if (bus.restore_done_o) begin
            got = 1'b1;
            lat = cnt;
            ptr = bus.restore_ptr_o;
         end
      end
      bus.restore_wr_ready_i = 1'b1;
      check("restore_completes", 64'(got), 64'd1);
      model_busy = 1'b0;
   endtask

   int          lat;
   logic [AW-1:0] ptr;
   int          done_base;
   bit          found;

   initial begin
      bus.commit_valid_i     = 1'b0;
      bus.commit_jumpop_i    = OpNone;
      bus.commit_retaddr_i   = '0;
      bus.restore_req_i      = 1'b0;
      bus.restore_wr_ready_i = 1'b1;
      model_clear();
      exp_next  = 0;
      beats_acc = 0;
      done_cnt  = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_valid", 64'(bus.restore_wr_valid_o), 64'd0);
      check("rst_stall", 64'(bus.commit_stall_o), 64'd0);
      check("rst_done", 64'(bus.restore_done_o), 64'd0);
      check("rst_ptr", 64'(bus.restore_ptr_o), 64'd0);

      // Three calls plus a non-jump, then a full-speed repair.
      commit(OpCall, 64'h8000_0104);
      commit(OpCall, 64'h8000_0208);
      commit(OpCall, 64'h8000_030C);
      commit(OpNone, 64'hDEAD_BEEF);
      restore(0, 1'b0, 64'd0, 1'b0, lat, ptr);
      check("t1_latency", 64'(lat), 64'd17);
      check("t1_ptr", 64'(ptr), 64'd3);
      check("t1_e0", beat_data[0], 64'h8000_0104);
      check("t1_e1", beat_data[1], 64'h8000_0208);
      check("t1_e2", beat_data[2], 64'h8000_030C);
      check("t1_e3", beat_data[3], 64'd0);
      check("t1_e15", beat_data[15], 64'd0);

      // Pops move head back but leave stale entries in place.
      do_reset();
      commit(OpCall, 64'h8000_0104);
      commit(OpCall, 64'h8000_0208);
      commit(OpCall, 64'h8000_030C);
      commit(OpRet, 64'd0);
      commit(OpRet, 64'd0);
      restore(0, 1'b0, 64'd0, 1'b0, lat, ptr);
      check("t2_ptr", 64'(ptr), 64'd1);
      check("t2_e1_stale", beat_data[1], 64'h8000_0208);
      check("t2_e2_stale", beat_data[2], 64'h8000_030C);

      // Overflow wrap: 17 pushes, one as call-and-return.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         commit((i == 5) ? OpCallRet : OpCall, 64'h9000_0000 + 64'(i * 4));
      end
`ifdef YSYX_22040210_RAS_COMMIT_PERF_EN
      check("t3_perf_ovf", 64'(perf_ovf), 64'd1);
      check("t3_perf_unf0", 64'(perf_unf), 64'd0);
`endif
      restore(0, 1'b0, 64'd0, 1'b0, lat, ptr);
      check("t3_ptr_wrap", 64'(ptr), 64'd1);
      check("t3_e0", beat_data[0], 64'h9000_0040);
      check("t3_e1", beat_data[1], 64'h9000_0004);
      check("t3_e5", beat_data[5], 64'h9000_0014);
      check("t3_e15", beat_data[15], 64'h9000_003C);
      // Underflow wrap: head 1 -> 0 -> 15.
      commit(OpRet, 64'd0);
      commit(OpRet, 64'd0);
      restore(0, 1'b0, 64'd0, 1'b0, lat, ptr);
      check("t3_ptr_under", 64'(ptr), 64'd15);
`ifdef YSYX_22040210_RAS_COMMIT_PERF_EN
      check("t3_perf_unf", 64'(perf_unf), 64'd1);
      check("t3_perf_ovf_kept", 64'(perf_ovf), 64'd1);
`endif

      // Back-pressured repair.
      restore(1, 1'b0, 64'd0, 1'b0, lat, ptr);
      check("t4_beats", 64'(beats_acc), 64'd16);
      check("t4_ptr", 64'(ptr), 64'd15);
      check("t4_slow", 64'(lat > 17), 64'd1);

      // Same-cycle call+request, ignored return mid-copy, restart at idx 7.
      do_reset();
      done_base = done_cnt;
      restore(0, 1'b1, 64'h1000, 1'b1, lat, ptr);
      check("t5_ptr", 64'(ptr), 64'd1);
      check("t5_e0", beat_data[0], 64'h1000);
      check("t5_latency", 64'(lat), 64'd25);
      repeat (3) @(posedge clk);
      #1;
      check("t5_one_done", 64'(done_cnt - done_base), 64'd1);

      // Asynchronous reset mid-copy.
      commit(OpCall, 64'h2222);
      @(posedge clk);
      #1;
      bus.restore_req_i = 1'b1;
      @(posedge clk);
      model_busy = 1'b1;
      #1;
      bus.restore_req_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (bus.restore_wr_valid_o && bus.restore_wr_idx_o == 4'd5) found = 1'b1;
      end
      check("t6_reach_idx5", 64'(found), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_valid", 64'(bus.restore_wr_valid_o), 64'd0);
      check("t6_async_stall", 64'(bus.commit_stall_o), 64'd0);
      check("t6_async_data", bus.restore_wr_data_o, 64'd0);
      model_clear();
      exp_next  = 0;
      beats_acc = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_idle_stall", 64'(bus.commit_stall_o), 64'd0);
      restore(0, 1'b0, 64'd0, 1'b0, lat, ptr);
      check("t6_ptr", 64'(ptr), 64'd0);
      check("t6_latency", 64'(lat), 64'd17);
      check("t6_e0", beat_data[0], 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
